trap_ctrl: RTL and testbench

- Trap/interrupt sequencer for the M-mode CSR file.
- Arbitrates synchronous exceptions, MRET requests and the three machine interrupt lines (ext/soft/timer).
- Drains the pipeline, then pulses the CSR file's trap or mret strobe with cause and pc.
- Issues a fetch redirect to the mtvec-derived handler address or to mepc.

---
 rtl/trap_ctrl.sv | 172 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl -- M-mode trap / interrupt sequencer.
//
// Picks one of a synchronous exception, a pending machine interrupt or an
// MRET while idle. It then drains the pipeline, pulses the CSR file's trap or
// mret strobe, and redirects fetch to the handler or to mepc.
//
// Ports:
//   ctrl_clk, ctrl_reset       clock, synchronous active-high reset
//   exc_valid/cause/pc         synchronous exception request
//   mret_valid                 MRET retiring
//   int_pc                     mepc value used for interrupts
//   irq_ext/soft/timer         raw machine interrupt levels
//   csr_mie, csr_mstatus_mie   interrupt enables
//   csr_mtvec, csr_mepc        handler base / return address
//   flush                      kill + stall pipeline while busy
//   pipe_idle                  pipeline empty, CSR writes committed
//   ctrl_trap, ctrl_mret       one-cycle CSR strobes
//   trap_info, trap_pc         {is_int, code} and mepc value
//   redirect_valid/pc/ready    fetch redirect handshake
//   drain_err                  one-cycle pulse on drain timeout
//
// Optional: define TRAP_CTRL_STATS_EN to add the trap_count, int_count and
// mret_count event counters.
module trap_ctrl #(
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic [31:0] int_pc,
  input  logic        irq_ext,
  input  logic        irq_soft,
  input  logic        irq_timer,
  input  logic [31:0] csr_mie,
  input  logic        csr_mstatus_mie,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        flush,
  input  logic        pipe_idle,
  output logic        ctrl_trap,
  output logic        ctrl_mret,
  output logic [4:0]  trap_info,
  output logic [31:0] trap_pc,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
`ifdef TRAP_CTRL_STATS_EN
  output logic [31:0] trap_count,
  output logic [31:0] int_count,
  output logic [31:0] mret_count,
`endif
  output logic        drain_err
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(DRAIN_TIMEOUT);

  state_t      state;
  logic        kind_mret;
  logic [7:0]  drain_cnt;
  logic [7:0]  drain_cnt_nxt;

  logic        mei, msi, mti, take_int;
  logic [3:0]  int_code;
  logic [31:0] mtvec_base;
  logic [31:0] tgt_pc;

  assign mei      = irq_ext   & csr_mie[11];
  assign msi      = irq_soft  & csr_mie[3];
  assign mti      = irq_timer & csr_mie[7];
  assign take_int = csr_mstatus_mie & (mei | msi | mti);
  assign int_code = mei ? 4'd11 : (msi ? 4'd3 : 4'd7);

  assign drain_cnt_nxt = drain_cnt + 8'd1;
  assign mtvec_base    = {csr_mtvec[31:2], 2'b00};

  // Sampled only in COMMIT, after the CSR file has seen the strobe's
  // preceding state, so MRET picks up the committed mepc.
  always_comb begin
    tgt_pc = mtvec_base;
    if (kind_mret)
      tgt_pc = csr_mepc;
    else if (trap_info[4] && csr_mtvec[1:0] == 2'b01)
      tgt_pc = mtvec_base + {26'd0, trap_info[3:0], 2'b00};
  end

  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      state          <= S_IDLE;
      kind_mret      <= 1'b0;
      drain_cnt      <= 8'd0;
      flush          <= 1'b0;
      ctrl_trap      <= 1'b0;
      ctrl_mret      <= 1'b0;
      trap_info      <= 5'd0;
      trap_pc        <= 32'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      drain_err      <= 1'b0;
    end else begin
      ctrl_trap <= 1'b0;
      ctrl_mret <= 1'b0;
      drain_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // MRET leaves trap_info/trap_pc holding the last trap's values.
          if (exc_valid) begin
            kind_mret <= 1'b0;
            trap_info <= {1'b0, exc_cause};
            trap_pc   <= exc_pc;
          end else if (take_int) begin
            kind_mret <= 1'b0;
            trap_info <= {1'b1, int_code};
            trap_pc   <= int_pc;
          end else if (mret_valid) begin
            kind_mret <= 1'b1;
          end
          if (exc_valid || take_int || mret_valid) begin
            state     <= S_DRAIN;
            flush     <= 1'b1;
            drain_cnt <= 8'd0;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt_nxt;
          // pipe_idle wins over a timeout landing on the same cycle.
          if (pipe_idle || drain_cnt_nxt == TIMEOUT) begin
            drain_err <= ~pipe_idle;
            ctrl_trap <= ~kind_mret;
            ctrl_mret <= kind_mret;
            state     <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          redirect_pc    <= tgt_pc;
          redirect_valid <= 1'b1;
          state          <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TRAP_CTRL_STATS_EN
  always_ff @(posedge ctrl_clk) begin
    if (ctrl_reset) begin
      trap_count <= 32'd0;
      int_count  <= 32'd0;
      mret_count <= 32'd0;
    end else if (state == S_COMMIT) begin
      if (kind_mret) begin
        mret_count <= mret_count + 32'd1;
      end else begin
        trap_count <= trap_count + 32'd1;
        if (trap_info[4]) int_count <= int_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// transaction-level model of the sequencer.
module tb_trap_ctrl;
  localparam int TO = 12;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset;
  logic        exc_valid, mret_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, int_pc;
  logic        irq_ext, irq_soft, irq_timer;
  logic [31:0] csr_mie, csr_mtvec, csr_mepc;
  logic        csr_mstatus_mie;
  logic        flush, pipe_idle, ctrl_trap, ctrl_mret;
  logic [4:0]  trap_info;
  logic [31:0] trap_pc, redirect_pc;
  logic        redirect_valid, redirect_ready, drain_err;

  int checks = 0;
  int errors = 0;
  int n_mret = 0;

  trap_ctrl #(.DRAIN_TIMEOUT(TO)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .int_pc(int_pc),
    .irq_ext(irq_ext), .irq_soft(irq_soft), .irq_timer(irq_timer),
    .csr_mie(csr_mie), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .flush(flush), .pipe_idle(pipe_idle),
    .ctrl_trap(ctrl_trap), .ctrl_mret(ctrl_mret),
    .trap_info(trap_info), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .drain_err(drain_err)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy phase: 0 idle, 1 draining, 2 strobe cycle, 3 awaiting fetch accept
  int          ph = 0;
  int          dcnt = 0;
  bit          m_is_mret = 0;
  bit          e_flush = 0, e_trap = 0, e_mret = 0, e_rv = 0, e_err = 0;
  logic [4:0]  e_info = 0;
  logic [31:0] e_pc = 0, e_rpc = 0;

  always @(posedge ctrl_clk) begin
    bit mei, msi, mti;
    int code;
    e_trap = 0; e_mret = 0; e_err = 0;
    if (ctrl_reset) begin
      ph = 0; dcnt = 0; m_is_mret = 0; e_flush = 0; e_rv = 0;
      e_info = 0; e_pc = 0; e_rpc = 0;
    end else begin
      case (ph)
        0: begin
          mei = irq_ext & csr_mie[11];
          msi = irq_soft & csr_mie[3];
          mti = irq_timer & csr_mie[7];
          if (exc_valid) begin
            e_info = {1'b0, exc_cause}; e_pc = exc_pc; m_is_mret = 0; ph = 1;
          end else if (csr_mstatus_mie && (mei || msi || mti)) begin
            code = mei ? 11 : (msi ? 3 : 7);
            e_info = {1'b1, 4'(code)}; e_pc = int_pc; m_is_mret = 0; ph = 1;
          end else if (mret_valid) begin
            m_is_mret = 1; ph = 1;
          end
          if (ph == 1) begin e_flush = 1; dcnt = 0; end
        end
        1: begin
          dcnt++;
          if (pipe_idle || dcnt == TO) begin
            e_err = !pipe_idle;
            if (m_is_mret) e_mret = 1; else e_trap = 1;
            ph = 2;
          end
        end
        2: begin
          if (m_is_mret) e_rpc = csr_mepc;
          else if (e_info[4] && csr_mtvec[1:0] == 2'd1)
            e_rpc = (csr_mtvec & 32'hFFFF_FFFC) + 32'(e_info[3:0]) * 4;
          else e_rpc = csr_mtvec & 32'hFFFF_FFFC;
          e_rv = 1; ph = 3;
        end
        default: if (redirect_ready) begin ph = 0; e_flush = 0; e_rv = 0; end
      endcase
    end
  end

  bit cmp_en = 0;
  always @(negedge ctrl_clk) begin
    if (ctrl_mret) n_mret++;
    if (cmp_en) begin
      chk("flush", 32'(flush), 32'(e_flush));
      chk("ctrl_trap", 32'(ctrl_trap), 32'(e_trap));
      chk("ctrl_mret", 32'(ctrl_mret), 32'(e_mret));
      chk("drain_err", 32'(drain_err), 32'(e_err));
      chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      chk("redirect_pc", redirect_pc, e_rpc);
      chk("trap_info", 32'(trap_info), 32'(e_info));
      chk("trap_pc", trap_pc, e_pc);
      chk("strobe_excl", 32'(ctrl_trap & ctrl_mret), 32'd0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge ctrl_clk); #2;
  endtask

  task automatic idle_inputs();
    exc_valid = 0; mret_valid = 0; irq_ext = 0; irq_soft = 0; irq_timer = 0;
    pipe_idle = 1; redirect_ready = 1;
  endtask

  // which: 0 ctrl_trap, 1 ctrl_mret, 2 redirect_valid, 3 drain_err, 4 flush low
  task automatic wait_for(input int which, input string nm, output int n);
    bit hit;
    n = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge ctrl_clk);
      case (which)
        0: hit = ctrl_trap;
        1: hit = ctrl_mret;
        2: hit = redirect_valid;
        3: hit = drain_err;
        default: hit = !flush;
      endcase
      if (hit) begin n = i; break; end
    end
    if (n < 0) begin
      checks++; errors++;
      $display("FAIL timeout_%s got=none want=event", nm);
    end
  endtask

  initial begin
    int n;
    int m0;
    ctrl_reset = 1; exc_cause = 0; exc_pc = 0; int_pc = 0;
    csr_mie = 0; csr_mstatus_mie = 0; csr_mtvec = 0; csr_mepc = 0;
    idle_inputs();
    tick(); tick();
    cmp_en = 1;
    @(negedge ctrl_clk);
    chk("rst_outputs", {flush, ctrl_trap, ctrl_mret, redirect_valid, drain_err}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    ctrl_reset = 0;
    tick();

    // Exception to mtvec=0x100
    csr_mtvec = 32'h100; exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h40;
    tick(); exc_valid = 0;
    wait_for(0, "exc_trap", n);
    chk("exc_latency", 32'(n), 32'd1);
    chk("exc_info", 32'(trap_info), 32'h02);
    chk("exc_pc", trap_pc, 32'h40);
    wait_for(2, "exc_rv", n);
    chk("exc_rpc", redirect_pc, 32'h100);
    wait_for(4, "exc_unflush", n);
    chk("exc_unflush_delay", 32'(n), 32'd0);
    tick();

    // Vectored timer interrupt, line dropped right after sampling
    csr_mtvec = 32'h201; csr_mie = 32'h80; csr_mstatus_mie = 1;
    irq_timer = 1; int_pc = 32'h88;
    tick(); irq_timer = 0;
    wait_for(0, "vec_trap", n);
    chk("vec_info", 32'(trap_info), 32'h17);
    chk("vec_pc", trap_pc, 32'h88);
    wait_for(2, "vec_rv", n);
    chk("vec_rpc", redirect_pc, 32'h21C);
    wait_for(4, "vec_unflush", n);
    tick();

    // Priority: exception beats interrupt and MRET
    csr_mtvec = 32'h100; csr_mie = 32'h800; m0 = n_mret;
    exc_valid = 1; exc_cause = 4'd5; exc_pc = 32'h1234; irq_ext = 1; mret_valid = 1;
    tick(); idle_inputs();
    wait_for(0, "pri_trap", n);
    chk("pri_info", 32'(trap_info), 32'h05);
    wait_for(4, "pri_unflush", n);
    chk("pri_no_mret", 32'(n_mret - m0), 32'd0);
    tick();

    // Masking
    irq_ext = 1; csr_mstatus_mie = 0; csr_mie = 32'h800;
    repeat (4) tick();
    chk("mask_mstatus", 32'(flush), 32'd0);
    csr_mstatus_mie = 1; csr_mie = 32'h88;
    repeat (4) tick();
    chk("mask_mie", 32'(flush), 32'd0);
    idle_inputs(); csr_mie = 0;
    tick();

    // MRET with slow drain
    csr_mepc = 32'h3C; m0 = n_mret;
    mret_valid = 1; pipe_idle = 0;
    tick(); mret_valid = 0;
    repeat (10) tick();
    chk("mret_early", 32'(n_mret - m0), 32'd0);
    pipe_idle = 1;
    wait_for(1, "mret_strobe", n);
    wait_for(2, "mret_rv", n);
    chk("mret_rpc", redirect_pc, 32'h3C);
    wait_for(4, "mret_unflush", n);
    chk("mret_once", 32'(n_mret - m0), 32'd1);
    tick();

    // Drain timeout
    exc_valid = 1; exc_cause = 4'd1; exc_pc = 32'h500; pipe_idle = 0;
    tick(); exc_valid = 0;
    wait_for(3, "to_err", n);
    chk("to_cycles", 32'(n), 32'(TO));
    chk("to_trap_with_err", 32'(ctrl_trap), 32'd1);
    pipe_idle = 1;
    wait_for(4, "to_unflush", n);
    tick();

    // Reset while in REDIRECT
    redirect_ready = 0; exc_valid = 1; exc_cause = 4'd3;
    tick(); exc_valid = 0;
    wait_for(2, "rst_rv", n);
    #1 ctrl_reset = 1;
    tick();
    @(negedge ctrl_clk);
    chk("rstmid_outputs", {flush, ctrl_trap, ctrl_mret, redirect_valid, drain_err}, 32'd0);
    chk("rstmid_info", {27'd0, trap_info}, 32'd0);
    ctrl_reset = 0; idle_inputs();
    tick();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      exc_valid       = ($urandom_range(0, 7) == 0);
      exc_cause       = 4'($urandom);
      exc_pc          = $urandom;
      mret_valid      = ($urandom_range(0, 7) == 0);
      int_pc          = $urandom;
      irq_ext         = ($urandom_range(0, 9) == 0);
      irq_soft        = ($urandom_range(0, 9) == 0);
      irq_timer       = ($urandom_range(0, 9) == 0);
      csr_mie         = $urandom & 32'h888;
      csr_mstatus_mie = $urandom_range(0, 1) == 1;
      csr_mtvec       = $urandom;
      csr_mepc        = $urandom;
      pipe_idle       = ($urandom_range(0, 9) < 7) || (i % 200 > 180);
      if (i % 200 > 150 && i % 200 <= 180) pipe_idle = 0;
      redirect_ready  = ($urandom_range(0, 9) < 6);
      ctrl_reset      = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
